// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/writeback control with fetch timeout and halt-on-error
module cpu_sequencer #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter logic [7:0]  FETCH_TIMEOUT = 8'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] instr,
   input  logic        dec_legal,
   input  logic        dec_rf_we,
   output logic        rf_we,
   output logic [31:0] pc,
   output logic [15:0] retired,
   output logic        halted,
   output logic [1:0]  err
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] EXEC   = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] HALT   = 3'd5;
   logic [2:0] state;
   logic [7:0] tcnt;
   assign imem_req  = state == FETCH;
   assign imem_addr = pc;
   assign rf_we     = (state == WB) && dec_rf_we;
   assign halted    = state == HALT;
   // State machine; ack takes priority over timeout, errors park the sequencer in HALT until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         instr   <= 32'h0;
         retired <= 16'h0;
         err     <= 2'd0;
         tcnt    <= 8'h0;
      end else begin
         case (state)
            IDLE:   state <= run ? FETCH : IDLE;
            FETCH: begin
               if (imem_ack) begin
                  instr <= imem_data;
                  tcnt  <= 8'h0;
                  state <= DECODE;
               end else if (tcnt == FETCH_TIMEOUT - 8'd1) begin
                  tcnt  <= 8'h0;
                  err   <= 2'd2;
                  state <= HALT;
               end else begin
                  tcnt  <= tcnt + 8'd1;
               end
            end
            DECODE: begin
               state <= dec_legal ? EXEC : HALT;
               err   <= dec_legal ? err : 2'd1;
            end
            EXEC:   state <= WB;
            WB: begin
               pc      <= pc + 32'd4;
               retired <= retired + 16'd1;
               state   <= run ? FETCH : IDLE;
            end
            HALT:   state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;
   localparam logic [31:0] ADDI = 32'h0010_0093;
   localparam logic [31:0] RTYP = 32'h0000_0033;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic run = 1'b0;
   logic imem_ack = 1'b0;
   logic [31:0] imem_data = 32'h0;
   logic imem_req, rf_we, halted, dec_legal, dec_rf_we;
   logic [31:0] imem_addr, instr, pc;
   logic [15:0] retired;
   logic [1:0] err;
   logic imem_req2, rf_we2, halted2, dec_legal2, dec_rf_we2;
   logic [31:0] imem_addr2, instr2, pc2;
   logic [15:0] retired2;
   logic [1:0] err2;
   int passed = 0;
   int total = 0;
   logic [63:0] sb[$];
   logic [63:0] ent;
   always #5 clk = ~clk;
   function automatic logic legal(input logic [31:0] x);
      return x[6:0] == 7'h13 && (x[14:12] == 3'd0 || x[14:12] == 3'd4 || x[14:12] == 3'd6 || x[14:12] == 3'd7);
   endfunction
   assign dec_legal  = legal(instr);
   assign dec_rf_we  = legal(instr) && instr[11:7] != 5'd0;
   assign dec_legal2 = legal(instr2);
   assign dec_rf_we2 = legal(instr2) && instr2[11:7] != 5'd0;
   cpu_sequencer u1 (
      .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr), .dec_legal(dec_legal),
      .dec_rf_we(dec_rf_we), .rf_we(rf_we), .pc(pc), .retired(retired), .halted(halted), .err(err)
   );
   cpu_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u2 (
      .clk(clk), .rst(rst), .run(run), .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr2), .dec_legal(dec_legal2),
      .dec_rf_we(dec_rf_we2), .rf_we(rf_we2), .pc(pc2), .retired(retired2), .halted(halted2), .err(err2)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      imem_ack = 1'b0;
      tick();
      rst = 1'b0;
   endtask
   task automatic pop_chk();
      if (sb.size() == 0) chk("sb_empty_at_wb", 32'd1, 32'd0);
      else begin
         ent = sb.pop_front();
         chk("wb_instr", instr, ent[63:32]);
         chk("wb_pc", pc, ent[31:0]);
      end
   endtask
   initial begin
      do_reset();
      chk("rst_req", {31'h0, imem_req}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc2", pc2, 32'hFFFF_FFFC);
      chk("rst_retired", {16'h0, retired}, 32'd0);
      chk("rst_err", {30'h0, err}, 32'd0);
      chk("rst_halted", {31'h0, halted}, 32'd0);
      chk("rst_rf_we", {31'h0, rf_we}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      // three back-to-back ADDIs; stray acks outside FETCH must be ignored
      run = 1'b1;
      tick();
      for (int k = 1; k <= 12; k++) begin
         chk($sformatf("b2b_rf_we_c%0d", k), {31'h0, rf_we}, {31'h0, k % 4 == 0});
         if (k == 5) begin
            chk("wrap_pc2", pc2, 32'h0);
            chk("wrap_retired2", {16'h0, retired2}, 32'd1);
         end
         if (imem_req) begin
            chk("fetch_addr", imem_addr, pc);
            imem_ack = 1'b1;
            imem_data = ADDI;
            sb.push_back({ADDI, pc});
         end else begin
            imem_ack = k % 4 == 3;
            imem_data = 32'hDEAD_BEEF;
         end
         if (rf_we) pop_chk();
         if (k == 12) run = 1'b0;
         tick();
      end
      imem_ack = 1'b0;
      chk("b2b_pc", pc, 32'd12);
      chk("b2b_retired", {16'h0, retired}, 32'd3);
      chk("b2b_idle_req", {31'h0, imem_req}, 32'd0);
      // run dropped during EXEC still completes the instruction
      run = 1'b1;
      tick();
      imem_ack = 1'b1;
      imem_data = ADDI;
      sb.push_back({ADDI, pc});
      tick();
      imem_ack = 1'b0;
      tick();
      run = 1'b0;
      tick();
      chk("drop_rf_we", {31'h0, rf_we}, 32'd1);
      if (rf_we) pop_chk();
      tick();
      chk("drop_retired", {16'h0, retired}, 32'd4);
      chk("drop_pc", pc, 32'd16);
      chk("drop_req", {31'h0, imem_req}, 32'd0);
      tick();
      chk("drop_req_hold", {31'h0, imem_req}, 32'd0);
      // illegal instruction halts without advancing pc
      run = 1'b1;
      tick();
      imem_ack = 1'b1;
      imem_data = RTYP;
      tick();
      imem_ack = 1'b0;
      chk("ill_dec_rf_we", {31'h0, rf_we}, 32'd0);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("ill_halted", {31'h0, halted}, 32'd1);
         chk("ill_err", {30'h0, err}, 32'd1);
         chk("ill_rf_we", {31'h0, rf_we}, 32'd0);
         chk("ill_req", {31'h0, imem_req}, 32'd0);
         tick();
      end
      chk("ill_pc", pc, 32'd16);
      // fetch timeout after exactly 16 FETCH cycles
      do_reset();
      run = 1'b1;
      tick();
      for (int k = 1; k <= 16; k++) begin
         chk($sformatf("to_req_c%0d", k), {31'h0, imem_req}, 32'd1);
         tick();
      end
      chk("to_halted", {31'h0, halted}, 32'd1);
      chk("to_err", {30'h0, err}, 32'd2);
      // ack on the 16th FETCH cycle wins over the timeout
      do_reset();
      tick();
      for (int k = 1; k < 16; k++) tick();
      chk("late_req", {31'h0, imem_req}, 32'd1);
      imem_ack = 1'b1;
      imem_data = ADDI;
      sb.push_back({ADDI, pc});
      tick();
      imem_ack = 1'b0;
      chk("late_halted", {31'h0, halted}, 32'd0);
      chk("late_err", {30'h0, err}, 32'd0);
      chk("late_instr", instr, ADDI);
      tick();
      tick();
      chk("late_rf_we", {31'h0, rf_we}, 32'd1);
      if (rf_we) pop_chk();
      tick();
      // reset while a fetch is pending
      chk("mid_req_pending", {31'h0, imem_req}, 32'd1);
      chk("mid_retired_pre", {16'h0, retired}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_req", {31'h0, imem_req}, 32'd0);
      chk("mid_pc", pc, 32'h0);
      chk("mid_retired", {16'h0, retired}, 32'd0);
      chk("mid_instr", instr, 32'h0);
      chk("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
